// File: rtl/mult_arbiter.sv
// mult_arbiter
// Shares one external 32-bit iterative multiply unit between NUM_REQ
// requesters. A request is accepted only while the arbiter is idle. The
// operands are latched and the unit is started. After 32 enable cycles the
// low product word is offered on the response port until the consumer
// accepts it.
//
// Build option:
//   MULT_ARB_RR_EN  defined   -> round-robin grant with a rotating pointer
//                   undefined -> fixed priority, lowest valid index wins
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake (one-hot ready)
//   req_a/req_b                 packed operands, slice i = [32*i+31:32*i]
//   req_sign                    per-requester two's-complement mode
//   rsp_valid/rsp_ready         result handshake
//   rsp_id, rsp_result          owner index and low 32 product bits
//   mul_start, mul_enable       multiply unit control
//   mul_multiplier/_multiplicand/_sign  multiply unit operands
//   mul_result                  multiply unit output (bit 32 unused)

module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_sign,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    mul_start,
    output logic                    mul_enable,
    output logic [31:0]             mul_multiplier,
    output logic [31:0]             mul_multiplicand,
    output logic                    mul_sign,
    input  logic [32:0]             mul_result
);

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [5:0]      cnt;
    logic            any_valid;
    logic [ID_W-1:0] grant_idx;
    logic            grant;
    logic [31:0]     hold_a;
    logic [31:0]     hold_b;
    logic            hold_sign;
    logic [ID_W-1:0] hold_id;
    logic [31:0]     a_slice [NUM_REQ];
    logic [31:0]     b_slice [NUM_REQ];
    logic            unused_mul_msb;

    assign unused_mul_msb = mul_result[32];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign a_slice[i] = req_a[32*i +: 32];
        assign b_slice[i] = req_b[32*i +: 32];
    end

    assign any_valid = |req_valid;
    assign grant     = (state == IDLE) && any_valid;

`ifdef MULT_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_cand;

    // Scan from the pointer upward (wrapping); scanning offsets from the
    // far end downward lets the closest valid requester overwrite the others.
    always_comb begin
        grant_idx = '0;
        rr_cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            rr_cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[rr_cand]) begin
                grant_idx = rr_cand;
            end
        end
    end

    // The pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    // Fixed priority: descending scan so the lowest valid index wins.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FLUSH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FLUSH:   if (cnt == 6'd1) state_next = IDLE;
            IDLE:    if (any_valid) state_next = LAUNCH;
            LAUNCH:  state_next = RUN;
            RUN:     if (cnt == 6'd1) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = FLUSH;
        endcase
    end

    // FLUSH and RUN both run the unit for exactly 32 enabled cycles.
    // FLUSH drains whatever the unreset multiply unit was doing.
    // RUN times a real operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 6'd32;
        end else begin
            unique case (state)
                FLUSH, RUN: cnt <= cnt - 6'd1;
                LAUNCH:     cnt <= 6'd32;
                default:    cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a    <= '0;
            hold_b    <= '0;
            hold_sign <= 1'b0;
            hold_id   <= '0;
        end else if (grant) begin
            hold_a    <= a_slice[grant_idx];
            hold_b    <= b_slice[grant_idx];
            hold_sign <= req_sign[grant_idx];
            hold_id   <= grant_idx;
        end
    end

    assign mul_multiplier   = hold_a;
    assign mul_multiplicand = hold_b;
    assign mul_sign         = hold_sign;

    always_comb begin
        req_ready  = '0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_result = '0;
        mul_start  = 1'b0;
        mul_enable = 1'b0;
        unique case (state)
            FLUSH:  mul_enable = 1'b1;
            IDLE:   if (any_valid) req_ready = NUM_REQ'(1) << grant_idx;
            LAUNCH: begin
                mul_start  = 1'b1;
                mul_enable = 1'b1;
            end
            RUN:    mul_enable = 1'b1;
            DONE:   begin
                rsp_valid  = 1'b1;
                rsp_id     = hold_id;
                rsp_result = mul_result[31:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter
// Drives mult_arbiter with directed and randomized requests. A small
// multiply-unit stand-in answers the DUT. A transaction-level model predicts
// every output each cycle. The model tracks time since reset and time since
// grant, and computes products with plain arithmetic.
// Build option MULT_ARB_RR_EN selects the round-robin expectations.

module tb_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sign;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  mul_start;
    logic                  mul_enable;
    logic [31:0]           mul_multiplier;
    logic [31:0]           mul_multiplicand;
    logic                  mul_sign;
    logic [32:0]           mul_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_sign         (req_sign),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_result       (rsp_result),
        .mul_start        (mul_start),
        .mul_enable       (mul_enable),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_sign         (mul_sign),
        .mul_result       (mul_result)
    );

    // Multiply unit stand-in. It has no reset and starts mid-count.
    // Its result is junk until 32 enabled cycles follow a start.
    // Bit 32 is set so a DUT that leaks it into the result is caught.
    logic [31:0] mu_a   = 32'h0;
    logic [31:0] mu_b   = 32'h0;
    logic [5:0]  mu_cnt = 6'd19;

    always @(posedge clk) begin
        if (mul_enable && mul_start) begin
            mu_a   <= mul_multiplier;
            mu_b   <= mul_multiplicand;
            mu_cnt <= 6'd32;
        end else if (mul_enable && mu_cnt != 6'd0) begin
            mu_cnt <= mu_cnt - 6'd1;
        end
    end

    assign mul_result = (mu_cnt == 6'd0) ? {1'b1, mu_a * mu_b} : 33'h0_5A5A_5A5A;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lowProduct(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa;
        longint pb;
        longint p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({32'b0, a});
            pb = longint'({32'b0, b});
        end
        p = pa * pb;
        return p[31:0];
    endfunction

    function automatic int onehotIdx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Model state: remaining flush cycles, age of the active job, its
    // operands, its expected result, and the rotation pointer.
    int          m_flush = 32;
    bit          m_busy  = 1'b0;
    int          m_age   = 0;
    logic [31:0] m_a     = 32'h0;
    logic [31:0] m_b     = 32'h0;
    logic        m_sign  = 1'b0;
    int          m_id    = 0;
    logic [31:0] m_res   = 32'h0;
    int          m_ptr   = 0;

    function automatic int pickGrant(input logic [NUM_REQ-1:0] v);
`ifdef MULT_ARB_RR_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Compare process: one check set per cycle, then advance the model.
    always @(negedge clk) begin
        int g;
        if (!rst_n) begin
            checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
            checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
            checkOutput("rst_rsp_result", 64'(rsp_result), 64'h0);
            checkOutput("rst_rsp_id", 64'(rsp_id), 64'h0);
            checkOutput("rst_mul_start", 64'(mul_start), 64'h0);
            checkOutput("rst_mul_enable", 64'(mul_enable), 64'h1);
            checkOutput("rst_hold", {mul_multiplier, mul_multiplicand}, 64'h0);
            checkOutput("rst_hold_sign", 64'(mul_sign), 64'h0);
            m_flush = 32;
            m_busy  = 1'b0;
            m_ptr   = 0;
            m_a     = '0;
            m_b     = '0;
            m_sign  = 1'b0;
        end else begin
            checkOutput("hold_operands", {mul_multiplier, mul_multiplicand}, {m_a, m_b});
            checkOutput("hold_sign", 64'(mul_sign), 64'(m_sign));
            if (m_flush > 0) begin
                checkOutput("flush_req_ready", 64'(req_ready), 64'h0);
                checkOutput("flush_rsp_valid", 64'(rsp_valid), 64'h0);
                checkOutput("flush_rsp_result", 64'(rsp_result), 64'h0);
                checkOutput("flush_ctrl", {mul_start, mul_enable}, 64'h1);
                m_flush--;
            end else if (!m_busy) begin
                g = pickGrant(req_valid);
                checkOutput("idle_req_ready", 64'(req_ready), (g < 0) ? 64'h0 : (64'h1 << g));
                checkOutput("idle_rsp_valid", 64'(rsp_valid), 64'h0);
                checkOutput("idle_rsp_result", 64'(rsp_result), 64'h0);
                checkOutput("idle_mul_start", 64'(mul_start), 64'h0);
                if (g >= 0) begin
                    m_busy = 1'b1;
                    m_age  = 0;
                    m_id   = g;
                    m_a    = req_a[32*g +: 32];
                    m_b    = req_b[32*g +: 32];
                    m_sign = req_sign[g];
                    m_res  = lowProduct(m_a, m_b, m_sign);
                    m_ptr  = (g + 1) % NUM_REQ;
                end
            end else begin
                m_age++;
                checkOutput("busy_req_ready", 64'(req_ready), 64'h0);
                if (m_age == 1) begin
                    checkOutput("launch_ctrl", {mul_start, mul_enable}, 64'h3);
                    checkOutput("launch_rsp_valid", 64'(rsp_valid), 64'h0);
                end else if (m_age <= 33) begin
                    checkOutput("run_ctrl", {mul_start, mul_enable}, 64'h1);
                    checkOutput("run_rsp_valid", 64'(rsp_valid), 64'h0);
                    checkOutput("run_rsp_result", 64'(rsp_result), 64'h0);
                end else begin
                    checkOutput("done_ctrl", {mul_start, mul_enable}, 64'h0);
                    checkOutput("done_rsp_valid", 64'(rsp_valid), 64'h1);
                    checkOutput("done_rsp_id", 64'(rsp_id), 64'(m_id));
                    checkOutput("done_rsp_result", 64'(rsp_result), 64'(m_res));
                    if (rsp_ready) m_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic s);
        req_valid[idx]     = v;
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
        req_sign[idx]      = s;
    endtask

    // Counts sampled cycles up to and including the one where idx is granted,
    // then steps past the grant edge.
    task automatic waitReady(input int idx, input int budget, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (req_ready[idx]) break;
            if (n >= budget) begin
                checkOutput("wait_ready_timeout", 64'h0, 64'h1);
                break;
            end
        end
        tick();
    endtask

    task automatic waitRsp(input int budget, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
            if (n >= budget) begin
                checkOutput("wait_rsp_timeout", 64'h0, 64'h1);
                break;
            end
        end
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 15));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: return 32'h8000_0000;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int gcyc[5];
        int gid[5];
        int rid[5];
        int ng;
        int nr;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sign  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checkOutput("lit_reset_enable", 64'(mul_enable), 64'h1);
        checkOutput("lit_reset_ready", 64'(req_ready), 64'h0);
        tick();

        // First request arrives during flush; 32 flush cycles precede the grant.
        applyStimulus(0, 1'b1, 32'd7, 32'd6, 1'b0);
        rst_n = 1'b1;
        waitReady(0, 60, n);
        checkOutput("lit_flush_len", 64'(n), 64'd33);
        applyStimulus(0, 1'b0, 32'd0, 32'd0, 1'b0);
        waitRsp(60, n);
        checkOutput("lit_latency", 64'(n), 64'd34);
        checkOutput("lit_7x6", 64'(rsp_result), 64'd42);
        checkOutput("lit_7x6_id", 64'(rsp_id), 64'd0);
        tick();

        applyStimulus(2, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1);
        waitReady(2, 10, n);
        applyStimulus(2, 1'b0, 32'd0, 32'd0, 1'b0);
        waitRsp(60, n);
        checkOutput("lit_signed", 64'(rsp_result), 64'hFFFF_FFF1);
        checkOutput("lit_signed_id", 64'(rsp_id), 64'd2);
        tick();

        applyStimulus(2, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        waitReady(2, 10, n);
        applyStimulus(2, 1'b0, 32'd0, 32'd0, 1'b0);
        waitRsp(60, n);
        checkOutput("lit_unsigned", 64'(rsp_result), 64'hFFFF_FFF1);
        tick();

        // Back-pressure in DONE with another requester waiting.
        rsp_ready = 1'b0;
        applyStimulus(1, 1'b1, 32'd123456, 32'd789, 1'b0);
        waitReady(1, 10, n);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0);
        applyStimulus(3, 1'b1, 32'd9, 32'd11, 1'b0);
        waitRsp(60, n);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("lit_hold_valid", 64'(rsp_valid), 64'h1);
            checkOutput("lit_hold_result", 64'(rsp_result), 64'd97406784);
            checkOutput("lit_hold_id", 64'(rsp_id), 64'd1);
            checkOutput("lit_hold_ready", 64'(req_ready), 64'h0);
        end
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("lit_regrant_next", 64'(req_ready), 64'h8);
        tick();
        applyStimulus(3, 1'b0, 32'd0, 32'd0, 1'b0);
        waitRsp(60, n);
        checkOutput("lit_regrant_result", 64'(rsp_result), 64'd99);
        tick();

        // Reset in the middle of RUN (cnt=17) with req1 still requesting.
        applyStimulus(1, 1'b1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        waitReady(1, 10, n);
        repeat (16) tick();
        pulseReset();
        waitReady(1, 60, n);
        checkOutput("lit_rst_flush_len", 64'(n), 64'd33);
        applyStimulus(1, 1'b0, 32'd0, 32'd0, 1'b0);
        waitRsp(60, n);
        checkOutput("lit_rst_result", 64'(rsp_result), 64'hFFFF_F448);
        checkOutput("lit_rst_id", 64'(rsp_id), 64'd1);
        tick();

        // Randomized traffic, with one reset landing somewhere in the middle.
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                applyStimulus(r, 1'($urandom_range(0, 2) == 0), pick32(), pick32(), 1'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (i == 1700) rst_n = 1'b0;
            if (i == 1702) rst_n = 1'b1;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;

        pulseReset();
        ng = 0;
        nr = 0;
        n  = 0;
`ifdef MULT_ARB_RR_EN
        for (int r = 0; r < NUM_REQ; r++) applyStimulus(r, 1'b1, 32'(r + 1), 32'd10, 1'b0);
        while ((ng < 5 || nr < 5) && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready != '0 && ng < 5) begin
                gcyc[ng] = n;
                gid[ng]  = onehotIdx(req_ready);
                ng++;
            end
            if (rsp_valid && rsp_ready && nr < 5) begin
                rid[nr] = int'(rsp_id);
                nr++;
            end
        end
        checkOutput("rr_grant_count", 64'(ng), 64'd5);
        checkOutput("rr_rsp_count", 64'(nr), 64'd5);
        for (int k = 0; k < 5; k++) begin
            checkOutput("rr_rsp_id", 64'(rid[k]), 64'(k % NUM_REQ));
            checkOutput("rr_grant_id", 64'(gid[k]), 64'(k % NUM_REQ));
            if (k > 0) checkOutput("rr_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd35);
        end
`else
        applyStimulus(1, 1'b1, 32'd3, 32'd4, 1'b0);
        applyStimulus(3, 1'b1, 32'd5, 32'd6, 1'b0);
        while ((ng < 4 || nr < 4) && n < 400) begin
            @(negedge clk);
            n++;
            if (req_ready != '0 && ng < 4) begin
                gid[ng] = onehotIdx(req_ready);
                ng++;
            end
            if (rsp_valid && rsp_ready && nr < 4) begin
                rid[nr] = int'(rsp_id);
                nr++;
            end
        end
        checkOutput("fp_rsp_count", 64'(nr), 64'd4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("fp_rsp_id", 64'(rid[k]), 64'd1);
            checkOutput("fp_grant_id", 64'(gid[k]), 64'd1);
        end
`endif
        tick();
        req_valid = '0;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
